// File: rtl/add_1bit_pkg.sv
// Shared types and constants for the registered 1-bit adder.
// Optional carry/counter logic in the top is guarded by ADD_1BIT_CARRY_EN.
package add_1bit_pkg;

  localparam int unsigned ADD_1BIT_CNT_W = 8;

  // Half-adder result, ordered so {carry, sum} reads as the 2-bit sum a + b
  typedef struct packed {
    logic carry;
    logic sum;
  } sum_carry_t;

  localparam logic C_RST  = 1'b0;
  localparam logic CO_RST = 1'b0;

endpackage

// File: rtl/add_1bit_reg_half_adder.sv
// Purely combinational half adder: s = x ^ y, k = x & y.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic k
);

  assign s = x ^ y;
  assign k = x & y;

endmodule

// File: rtl/add_1bit_reg.sv
// Registered 1-bit adder: c = a ^ b one cycle after sampling.
// Define ADD_1BIT_CARRY_EN to add the registered carry `co` and a saturating carry counter.
module add_1bit_reg
  import add_1bit_pkg::*;
#(
  parameter int unsigned CNT_W = ADD_1BIT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  output logic             c
`ifdef ADD_1BIT_CARRY_EN
  ,
  output logic             co,
  output logic [CNT_W-1:0] carry_cnt
`endif
);

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("add_1bit_reg: CNT_W must be at least 1");
  end

  sum_carry_t ha;

  half_adder u_half_adder (
    .x (a),
    .y (b),
    .s (ha.sum),
    .k (ha.carry)
  );

  logic c_q, c_d;

  always_comb begin
    c_d = ha.sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q <= C_RST;
    end else begin
      c_q <= c_d;
    end
  end

  assign c = c_q;

`ifdef ADD_1BIT_CARRY_EN
  logic             co_q, co_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter holds at all-ones instead of wrapping
  always_comb begin
    co_d  = ha.carry;
    cnt_d = cnt_q;
    if (ha.carry && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      co_q  <= CO_RST;
      cnt_q <= '0;
    end else begin
      co_q  <= co_d;
      cnt_q <= cnt_d;
    end
  end

  assign co        = co_q;
  assign carry_cnt = cnt_q;
`else
  // Carry is dropped in this build; tie it off so it is visibly intentional
  logic ha_carry_unused;
  assign ha_carry_unused = ha.carry;
`endif

endmodule

// File: tb/tb_add_1bit_reg.sv
// Self-checking bench for add_1bit_reg; carry checks are active when ADD_1BIT_CARRY_EN is defined.
module tb_add_1bit_reg;

  localparam int unsigned TB_CNT_W = 2;
  localparam int          CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic clk;
  logic rst_n;
  logic a;
  logic b;
  logic c;
`ifdef ADD_1BIT_CARRY_EN
  logic                co;
  logic [TB_CNT_W-1:0] carry_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, derived from integer addition of the sampled operands
  int exp_c   = 0;
  int exp_co  = 0;
  int exp_cnt = 0;

  add_1bit_reg #(
    .CNT_W (TB_CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .c         (c)
`ifdef ADD_1BIT_CARRY_EN
    ,
    .co        (co),
    .carry_cnt (carry_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_c"}, 32'(c), 32'(exp_c));
`ifdef ADD_1BIT_CARRY_EN
    chk({tag, "_co"}, 32'(co), 32'(exp_co));
    chk({tag, "_cnt"}, 32'(carry_cnt), 32'(exp_cnt));
`endif
  endtask

  task automatic model_reset();
    exp_c   = 0;
    exp_co  = 0;
    exp_cnt = 0;
  endtask

  // Wait for a rising edge and advance the model with the operands sampled there
  task automatic edge_update();
    int sum;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      sum     = int'(a) + int'(b);
      exp_c   = sum % 2;
      exp_co  = sum / 2;
      exp_cnt = (exp_cnt + exp_co > CNT_MAX) ? CNT_MAX : exp_cnt + exp_co;
    end
  endtask

  task automatic cycle(input string tag);
    edge_update();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    int tt_a [4] = '{0, 1, 0, 1};
    int tt_b [4] = '{0, 0, 1, 1};

    // Reset held with a=1, b=0
    rst_n = 1'b0;
    a     = 1'b1;
    b     = 1'b0;
    #1;
    check_all("rst_async");
    for (int i = 0; i < 3; i++) cycle("rst_hold");
    rst_n = 1'b1;
    cycle("rst_release");

    // Exhaustive truth table, each pair held for two cycles
    for (int i = 0; i < 4; i++) begin
      a = 1'(tt_a[i]);
      b = 1'(tt_b[i]);
      cycle("tt_first");
      cycle("tt_second");
    end

    // Latency: raise a just after a rising edge
    a = 1'b0;
    b = 1'b0;
    edge_update();
    #1 a = 1'b1;
    #2 chk("lat_between_edges", 32'(c), 32'(0));
    @(negedge clk);
    check_all("lat_hold");
    cycle("lat_update");

    // Asynchronous reset pulse entirely between clock edges, with c=1
    #1 rst_n = 1'b0;
    #1 model_reset();
    check_all("async_mid");
    #1 rst_n = 1'b1;
    cycle("async_recover");

`ifdef ADD_1BIT_CARRY_EN
    // Counter saturation from zero: expected 1, 2, 3, 3, 3 for a 2-bit counter
    rst_n = 1'b0;
    #1 model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    a     = 1'b1;
    b     = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle("sat");
      chk("sat_abs", 32'(carry_cnt), 32'((i + 1 > 3) ? 3 : i + 1));
    end
`endif

    // Random operands
    for (int i = 0; i < 500; i++) begin
      a = 1'($urandom_range(1, 0));
      b = 1'($urandom_range(1, 0));
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
